// File: rtl/visited_scheduler_if.sv
// Handshake, table-access and result signals between visited_scheduler and its
// environment (direction source, visited_positions table, result consumer).
interface visited_scheduler_if #(
    parameter int POSITION_WIDTH = 8,
    parameter int COUNT_WIDTH    = 16
);
    logic                      dir_valid;
    logic [1:0]                dir_code;
    logic                      dir_ready;
    logic                      input_end;
    logic                      pos_change;
    logic [POSITION_WIDTH-1:0] pos_x;
    logic [POSITION_WIDTH-1:0] pos_y;
    logic                      lookup_valid;
    logic                      lookup_already_visited;
    logic [COUNT_WIDTH-1:0]    unique_count;
    logic                      done;

    modport master (
        input  dir_valid, dir_code, input_end, lookup_valid, lookup_already_visited,
        output dir_ready, pos_change, pos_x, pos_y, unique_count, done
    );

    modport slave (
        output dir_valid, dir_code, input_end, lookup_valid, lookup_already_visited,
        input  dir_ready, pos_change, pos_x, pos_y, unique_count, done
    );
endinterface

// File: rtl/visited_scheduler.sv
// Moves one or two agents by a direction stream, issues one visited-table access per
// move and counts the table's first-visit answers until the stream is drained.
module visited_scheduler #(
    parameter int POSITION_WIDTH = 8,
    parameter int AGENT_COUNT    = 2,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    visited_scheduler_if.master bus
);
    typedef enum logic [1:0] {ORIGIN, RUN, DRAIN, DONE} state_e;

    localparam logic [POSITION_WIDTH-1:0] ORIGIN_POS = {1'b1, {(POSITION_WIDTH-1){1'b0}}};
    localparam logic [POSITION_WIDTH-1:0] POS_ONE    = {{(POSITION_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]    CNT_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                                     state_q, state_d;
    logic [AGENT_COUNT-1:0][POSITION_WIDTH-1:0] ax_q, ax_d, ay_q, ay_d;
    logic [POSITION_WIDTH-1:0]                  px_q, px_d, py_q, py_d, cur_x, cur_y;
    logic                                       sel_q, sel_d, end_q, end_d, pc_q, pc_d;
    logic [1:0]                                 outst_q, outst_d, win_q, win_d;
    logic [COUNT_WIDTH-1:0]                     uniq_q, uniq_d;
    logic                                       agent, origin_now, issue, resp;

    assign agent      = (AGENT_COUNT > 1) ? sel_q : 1'b0;
    assign origin_now = (state_q == ORIGIN) && !reset;
    assign issue      = pc_q || origin_now;
    // A result counts only against a request still outstanding; the window after
    // reset release swallows results of accesses abandoned by the reset.
    assign resp       = bus.lookup_valid && (win_q == 2'd0) && (outst_q != 2'd0);

    always_comb begin
        cur_x = ORIGIN_POS;
        cur_y = ORIGIN_POS;
        for (int a = 0; a < AGENT_COUNT; a++)
            if (a == int'(agent)) begin
                cur_x = ax_q[a];
                cur_y = ay_q[a];
            end
    end

    always_comb begin
        state_d       = state_q;
        ax_d          = ax_q;
        ay_d          = ay_q;
        px_d          = px_q;
        py_d          = py_q;
        sel_d         = sel_q;
        end_d         = end_q;
        pc_d          = 1'b0;
        bus.dir_ready = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            ORIGIN: begin
                ax_d    = {AGENT_COUNT{ORIGIN_POS}};
                ay_d    = {AGENT_COUNT{ORIGIN_POS}};
                state_d = RUN;
            end
            RUN: begin
                bus.dir_ready = 1'b1;
                if (bus.dir_valid) begin
                    px_d = cur_x;
                    py_d = cur_y;
                    case (bus.dir_code)
                        2'b00:   py_d = cur_y + POS_ONE;
                        2'b01:   py_d = cur_y - POS_ONE;
                        2'b10:   px_d = cur_x + POS_ONE;
                        default: px_d = cur_x - POS_ONE;
                    endcase
                    for (int a = 0; a < AGENT_COUNT; a++)
                        if (a == int'(agent)) begin
                            ax_d[a] = px_d;
                            ay_d[a] = py_d;
                        end
                    pc_d  = 1'b1;
                    sel_d = (AGENT_COUNT > 1) ? !sel_q : 1'b0;
                end
                if (bus.input_end) end_d = 1'b1;
                if (bus.input_end || end_q) state_d = DRAIN;
            end
            DRAIN: if (!pc_q && outst_q == 2'd0) state_d = DONE;
            default: bus.done = 1'b1;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (issue && !resp)      outst_d = outst_q + 2'd1;
        else if (!issue && resp) outst_d = outst_q - 2'd1;
        win_d  = (win_q != 2'd0) ? win_q - 2'd1 : win_q;
        uniq_d = uniq_q;
        if (resp && !bus.lookup_already_visited && uniq_q != '1) uniq_d = uniq_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ORIGIN;
            ax_q    <= {AGENT_COUNT{ORIGIN_POS}};
            ay_q    <= {AGENT_COUNT{ORIGIN_POS}};
            px_q    <= ORIGIN_POS;
            py_q    <= ORIGIN_POS;
            sel_q   <= 1'b0;
            end_q   <= 1'b0;
            pc_q    <= 1'b0;
            outst_q <= 2'd0;
            win_q   <= 2'd2;
            uniq_q  <= '0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            px_q    <= px_d;
            py_q    <= py_d;
            sel_q   <= sel_d;
            end_q   <= end_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            win_q   <= win_d;
            uniq_q  <= uniq_d;
        end
    end

    assign bus.pos_change   = issue;
    assign bus.pos_x        = origin_now ? ORIGIN_POS : px_q;
    assign bus.pos_y        = origin_now ? ORIGIN_POS : py_q;
    assign bus.unique_count = uniq_q;
endmodule

// File: tb/tb_visited_scheduler.sv
// Drives one direction stream into two scheduler configurations at once and checks
// them against a coordinate-level model and a latency-2 visited table model.
module tb_visited_scheduler;
    typedef logic [1:0] code_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_code = 2'b00;
    logic       input_end = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [1:0] done_w;
    logic [31:0] uniq_w [2];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int PW   = (g == 0) ? 8 : 2;
        localparam int AC   = (g == 0) ? 2 : 1;
        localparam int CW   = (g == 0) ? 16 : 3;
        localparam int MASK = (1 << PW) - 1;
        localparam int ORG  = 1 << (PW - 1);
        localparam int UMAX = (1 << CW) - 1;

        visited_scheduler_if #(.POSITION_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();
        visited_scheduler #(.POSITION_WIDTH(PW), .AGENT_COUNT(AC), .COUNT_WIDTH(CW)) dut (
            .clk(clk), .reset(reset), .bus(bus)
        );

        int ax[2], ay[2];
        int sel, ex, ey, ag, k, nv;
        bit first, running, pend;
        bit vis[int];
        bit tbl[int];
        bit [1:0] pv = 2'b00, pa = 2'b00;
        bit lv_r = 1'b0, la_r = 1'b0;

        assign bus.dir_valid              = dir_valid;
        assign bus.dir_code               = dir_code;
        assign bus.input_end              = input_end;
        assign bus.lookup_valid           = lv_r;
        assign bus.lookup_already_visited = la_r;
        assign done_w[g]                  = bus.done;
        assign uniq_w[g]                  = 32'(bus.unique_count);

        always @(negedge clk) begin
            if (reset) begin
                chk($sformatf("c%0d rst dir_ready", g), 32'(bus.dir_ready), 0);
                chk($sformatf("c%0d rst pos_change", g), 32'(bus.pos_change), 0);
                chk($sformatf("c%0d rst pos_x", g), 32'(bus.pos_x), ORG);
                chk($sformatf("c%0d rst pos_y", g), 32'(bus.pos_y), ORG);
                chk($sformatf("c%0d rst unique", g), 32'(bus.unique_count), 0);
                chk($sformatf("c%0d rst done", g), 32'(bus.done), 0);
                for (int i = 0; i < 2; i++) begin ax[i] = ORG; ay[i] = ORG; end
                sel = 0; first = 1; running = 0; pend = 0;
                vis.delete();
                tbl.delete();
            end else begin
                chk($sformatf("c%0d pos_change", g), 32'(bus.pos_change), 32'(first || pend));
                if (first) begin ex = ORG; ey = ORG; vis[ORG * 256 + ORG] = 1'b1; end
                if (first || pend) begin
                    chk($sformatf("c%0d pos_x", g), 32'(bus.pos_x), ex);
                    chk($sformatf("c%0d pos_y", g), 32'(bus.pos_y), ey);
                end
                chk($sformatf("c%0d dir_ready", g), 32'(bus.dir_ready), 32'(running));
                if (running) chk($sformatf("c%0d early done", g), 32'(bus.done), 0);
                if (bus.done) begin
                    nv = vis.num();
                    chk($sformatf("c%0d unique", g), 32'(bus.unique_count), (nv < UMAX) ? nv : UMAX);
                end
                pend = 0;
                if (running && bus.dir_valid) begin
                    ag = (AC > 1) ? sel : 0;
                    case (bus.dir_code)
                        2'b00:   ay[ag] = (ay[ag] + 1) & MASK;
                        2'b01:   ay[ag] = (ay[ag] - 1) & MASK;
                        2'b10:   ax[ag] = (ax[ag] + 1) & MASK;
                        default: ax[ag] = (ax[ag] - 1) & MASK;
                    endcase
                    ex = ax[ag]; ey = ay[ag]; pend = 1;
                    vis[ex * 256 + ey] = 1'b1;
                    sel = 1 - sel;
                end
                if (running && bus.input_end) running = 0;
                if (first) begin first = 0; running = 1; end
            end
            // visited table: answers two cycles after the access, keeps running through reset
            lv_r = pv[1]; la_r = pa[1];
            pv[1] = pv[0]; pa[1] = pa[0];
            pv[0] = bus.pos_change; pa[0] = 1'b0;
            if (bus.pos_change) begin
                k = int'(bus.pos_x) * 256 + int'(bus.pos_y);
                pa[0] = tbl.exists(k) ? 1'b1 : 1'b0;
                tbl[k] = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic code_q_t to_codes(input string s);
        code_q_t q;
        for (int i = 0; i < s.len(); i++)
            case (s[i])
                "^":     q.push_back(2'b00);
                "v":     q.push_back(2'b01);
                ">":     q.push_back(2'b10);
                default: q.push_back(2'b11);
            endcase
        return q;
    endfunction

    // Starts in the ORIGIN cycle (first beat already presented there), ends a few cycles into DONE.
    task automatic run_stream(input code_q_t codes, input int gap_pct, input bit end_on_last,
                              input bit do_rst, output int lat);
        int t0, n, c;
        n = codes.size();
        if (do_rst) do_reset();
        t0 = cyc;
        dir_valid = (n > 0);
        if (n > 0) dir_code = codes[0];
        step();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                dir_valid = 1'b0;
                dir_code = 2'($urandom_range(3));
                step();
            end
            dir_valid = 1'b1;
            dir_code  = codes[i];
            input_end = end_on_last && (i == n - 1);
            step();
        end
        dir_valid = 1'b0;
        input_end = 1'b0;
        if (!end_on_last || n == 0) begin input_end = 1'b1; step(); input_end = 1'b0; end
        c = 0;
        while (done_w != 2'b11 && c < 40) begin
            dir_valid = 1'($urandom_range(1));
            step();
            c++;
        end
        lat = cyc - t0;
        chk("done", 32'(done_w), 3);
        repeat (3) begin
            dir_valid = 1'($urandom_range(1));
            input_end = 1'($urandom_range(1));
            step();
        end
        dir_valid = 1'b0;
        input_end = 1'b0;
    endtask

    string   dirs [5] = '{"^v", "^>v<", "^v^v^v^v^v", "<<<<", ""};
    int      exp0 [5] = '{3, 3, 11, 3, 1};
    int      exp1 [5] = '{2, 4, 2, 4, 1};

    initial begin
        code_q_t q;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_stream(to_codes(dirs[i]), 0, 1'(i % 2), 1'b1, lat);
            chk($sformatf("spec c0 '%s'", dirs[i]), uniq_w[0], exp0[i]);
            chk($sformatf("spec c1 '%s'", dirs[i]), uniq_w[1], exp1[i]);
            if (i == 4) chk("end-only latency<=5", 32'(lat <= 5), 1);
        end
        for (int r = 0; r < 10; r++) begin
            q.delete();
            repeat ($urandom_range(0, 40)) q.push_back(2'($urandom_range(3)));
            run_stream(q, 30, 1'($urandom_range(1)), 1'b1, lat);
        end
        // reset in the middle of a busy stream, results still in flight
        do_reset();
        dir_valid = 1'b1;
        repeat (7) begin dir_code = 2'($urandom_range(3)); step(); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        repeat (12) q.push_back(2'($urandom_range(3)));
        run_stream(q, 20, 1'b0, 1'b0, lat);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/visited_scheduler.md
VISITED_SCHEDULER -- requirements
Module: visited_scheduler

Interface
REQ-001 SHALL have parameter POSITION_WIDTH, default 8, meaning the per-axis coordinate width; it must match the attached visited_positions table.
REQ-002 SHALL have parameter AGENT_COUNT, default 2, meaning the number of movers sharing the table; legal values are 1 and 2.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, meaning the width of unique_count.
REQ-004 clk  input  1  clock; one clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 dir_valid  input  1  direction beat present.
REQ-007 dir_code  input  2  move code: 00=up(y+1), 01=down(y-1), 10=right(x+1), 11=left(x-1).
REQ-008 dir_ready  output  1  beat accepted when dir_valid && dir_ready.
REQ-009 input_end  input  1  single-cycle pulse marking end of the direction stream.
REQ-010 pos_change  output  1  table access strobe to visited_positions.
REQ-011 pos_x, pos_y  output  POSITION_WIDTH each  table access coordinates, valid when pos_change=1.
REQ-012 lookup_valid, lookup_already_visited  input  1 each  table results from visited_positions.
REQ-013 unique_count  output  COUNT_WIDTH  number of distinct positions visited.
REQ-014 done  output  1  final result valid; held high.

Function
REQ-015 SHALL implement FSM states ORIGIN, RUN, DRAIN, DONE; reset state is ORIGIN.
REQ-016 ORIGIN SHALL hold for exactly one cycle:
- dir_ready=0, pos_change=1, pos_x=pos_y=ORIGIN=2**(POSITION_WIDTH-1).
- Every agent position is set to ORIGIN.
- Next state is RUN.
REQ-017 RUN SHALL drive dir_ready=1 every cycle, with no beat dropped or duplicated.
REQ-018 On acceptance at cycle t, the selected agent's position SHALL update by the move code, and pos_change=1 with the new position SHALL be driven at cycle t+1.
REQ-019 Coordinate arithmetic SHALL be modulo 2**POSITION_WIDTH (wrap-around, no saturation).
REQ-020 Agent selection SHALL alternate per accepted beat, starting with agent 0 after reset; with AGENT_COUNT=1, agent 0 is always selected.
REQ-021 pos_change SHALL be 0 in any cycle not following an acceptance or ORIGIN.
REQ-022 Issue rate SHALL be at most one access per cycle, with back-to-back issue allowed.
REQ-023 An outstanding-lookup counter SHALL:
- increment on pos_change and decrement on lookup_valid;
- handle simultaneous events as no net change;
- be sized for a 2-cycle table latency (max 2).
REQ-024 unique_count SHALL increment on each lookup_valid with lookup_already_visited=0 and SHALL saturate at all-ones.
REQ-025 input_end in RUN SHALL latch end-seen. When it coincides with an accepted beat, that beat SHALL be processed normally.
REQ-026 With end-seen set, RUN SHALL transition to DRAIN on the next cycle; dir_ready=0 from that cycle on.
REQ-027 DRAIN SHALL move to DONE when no pos_change is pending and the outstanding counter is 0.
REQ-028 DONE SHALL hold done=1, dir_ready=0, pos_change=0, and a frozen unique_count until reset.
REQ-029 input_end outside RUN SHALL be ignored; dir_valid outside RUN SHALL not be accepted.

Reset
REQ-030 Reset SHALL asynchronously force the following, regardless of state:
- state=ORIGIN, dir_ready=0, pos_change=0, pos_x=pos_y=ORIGIN;
- unique_count=0, done=0, outstanding=0, end-seen=0, agent select=0.
REQ-031 Reset mid-operation SHALL abandon in-flight lookups; results returning after reset deassertion SHALL be ignored for one 2-cycle window.
REQ-032 This block SHALL not clear the visited table; the table content is owned by visited_positions.

Verification
REQ-033 AGENT_COUNT=2, stream "^v" then input_end -> done=1, unique_count=3.
REQ-034 AGENT_COUNT=2, "^>v<" -> 3; "^v^v^v^v^v" -> 11.
REQ-035 AGENT_COUNT=1, "^>v<" -> 4; "^v^v^v^v^v" -> 2.
REQ-036 AGENT_COUNT=1, POSITION_WIDTH=2, "<<<<" -> x sequence 1,0,3,2; unique_count=4.
REQ-037 input_end only, no beats -> unique_count=1, done=1 within 5 cycles of reset release.
REQ-038 dir_valid held high from reset release:
- dir_ready=0 in the ORIGIN cycle and then 1;
- reset asserted mid-stream -> outputs at reset values immediately, with no done assertion.
